// File: rtl/uart_rx_vote_sampler.sv
// UART RX oversampling majority voter: captures NSAMP samples centred on each bit period
// and emits the voted bit with a one-cycle valid strobe, a noise flag and a config-error flag.
module uart_rx_vote_sampler #(
    parameter int PRESCALE_W = 6,
    parameter int NSAMP      = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  dat_samp_en,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic                  RX_IN,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  noise_err,
    output logic                  cfg_err
);

    localparam int H  = (NSAMP - 1) / 2;
    localparam int AW = PRESCALE_W + 4;
    localparam int CW = $clog2(NSAMP + 1);

    logic [PRESCALE_W-1:0] mid;
    logic [NSAMP-1:0]      samp, mask, hit, cap, samp_nx, mask_nx;
    logic [CW-1:0]         ones, ones_nx;
    logic                  cfg_bad, vote;

    always_comb begin
        mid     = Prescale >> 1;
        cfg_bad = AW'(mid) < AW'(H + 1);
        // edge_cnt == M-H+k rearranged as edge_cnt+H == M+k so nothing wraps when M < H
        for (int unsigned k = 0; k < NSAMP; k++) begin
            hit[k] = (AW'(edge_cnt) + AW'(H)) == (AW'(mid) + AW'(k));
        end
        cap = '0;
        if (dat_samp_en && !cfg_err && edge_cnt != '0) begin
            cap = hit & ~mask;
        end
        samp_nx = (samp & ~cap) | (cap & {NSAMP{RX_IN}});
        mask_nx = mask | cap;
        ones_nx = ones + CW'(RX_IN && (|cap));
        vote    = cap[NSAMP-1] && (&mask_nx);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp         <= '0;
            mask         <= '0;
            ones         <= '0;
            sampled_bit  <= 1'b0;
            sample_valid <= 1'b0;
            noise_err    <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            cfg_err      <= cfg_bad;
            sample_valid <= 1'b0;
            if (!dat_samp_en || edge_cnt == '0) begin
                samp <= '0;
                mask <= '0;
                ones <= '0;
            end else begin
                samp <= samp_nx;
                mask <= mask_nx;
                ones <= ones_nx;
                if (vote) begin
                    sample_valid <= 1'b1;
                    sampled_bit  <= ones_nx > CW'(H);
                    noise_err    <= (samp_nx != '0) && (samp_nx != '1);
                end
            end
        end
    end

endmodule
